// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads one instruction word per fetch_start via mem_req/mem_ack and latches it into IR.
// Ack to ir_valid is one edge; mem_req holds until ack, and a missing ack for MAX_WAIT cycles parks the unit in ERR until reset.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [1:0]        pc_src,
    input  logic [31:0]       branch_off,
    input  logic [ADDR_W-1:0] reg_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       IR,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] last_pc,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] branch_tgt;

    // pc only changes outside WAIT, so it doubles as the held request address
    assign mem_addr   = pc;
    assign cnt_inc    = wait_cnt + CNT_W'(1);
    assign off_ext    = ADDR_W'($signed(branch_off));
    assign branch_tgt = last_pc + (off_ext << 2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            last_pc   <= RESET_PC;
            IR        <= '0;
            mem_req   <= 1'b0;
            ir_valid  <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pc_load) begin
                        case (pc_src)
                            2'b01:   pc <= {branch_tgt[ADDR_W-1:2], 2'b00};
                            2'b10:   pc <= {reg_target[ADDR_W-1:2], 2'b00};
                            default: pc <= pc;
                        endcase
                    end else if (fetch_start) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        IR       <= mem_rdata;
                        last_pc  <= pc;
                        pc       <= pc + ADDR_W'(4);
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        ir_valid <= 1'b1;
                    end else begin
                        wait_cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(MAX_WAIT)) begin
                            state     <= ERR;
                            mem_req   <= 1'b0;
                            busy      <= 1'b0;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table of redirect+fetch records, IR scoreboard, hand-written timeout/reset sequences.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] branch_off = '0;
    logic [31:0] reg_target = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] IR;
    logic [31:0] pc;
    logic [31:0] last_pc;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .MAX_WAIT(15)) dut (
        .clock(clock), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
        .pc_src(pc_src), .branch_off(branch_off), .reg_target(reg_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .IR(IR), .pc(pc), .last_pc(last_pc), .ir_valid(ir_valid), .busy(busy),
        .fetch_err(fetch_err)
    );

    typedef struct {
        logic [31:0] ir;
        logic [31:0] last_pc;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        bit          pc_load;
        bit [1:0]    pc_src;
        bit [31:0]   branch_off;
        bit [31:0]   reg_target;
        bit          with_start;
        int          delay;
        bit [31:0]   rdata;
        bit [31:0]   exp_pc;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_v = 1'b0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every IR load is matched against the queue; any load with nothing outstanding is an error.
    always @(posedge clock) begin
        #1;
        if (prev_v) check("ir_valid_one_cycle", ir_valid, 0);
        if (sb.size() == 0) begin
            check("spurious_ir_valid", ir_valid, 0);
        end else if (ir_valid) begin
            mon_e = sb.pop_front();
            check("sb_IR", IR, mon_e.ir);
            check("sb_last_pc", last_pc, mon_e.last_pc);
            check("sb_pc", pc, mon_e.pc);
        end
        prev_v = ir_valid;
    end

    // Junk redirects and fetch_start are driven during WAIT to prove they are ignored.
    task automatic do_fetch(input int delay, input logic [31:0] rdata, input logic [31:0] addr);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        sb.push_back('{rdata, addr, addr + 32'd4});
        for (int i = 0; i <= delay; i++) begin
            check("mem_req_wait", mem_req, 1);
            check("mem_addr_wait", mem_addr, addr);
            check("busy_wait", busy, 1);
            if (i == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                pc_load     = 1'b1;
                pc_src      = 2'b10;
                reg_target  = 32'hDEAD_BEE0;
                fetch_start = 1'b1;
                mem_rdata   = ~rdata;
            end
            tick();
        end
        mem_ack = 1'b0; pc_load = 1'b0; fetch_start = 1'b0;
        check("ack_mem_req", mem_req, 0);
        check("ack_busy", busy, 0);
        check("ack_ir_valid", ir_valid, 1);
        check("ack_err", fetch_err, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 0,  32'h9100_0421, 32'h0000_0000};
        vecs[1] = '{1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 5,  32'hA5A5_0001, 32'h0000_0004};
        vecs[2] = '{1'b1, 2'b10, 32'h0,        32'h0000_0103, 1'b0, 1,  32'h1111_1111, 32'h0000_0100};
        vecs[3] = '{1'b1, 2'b01, 32'hFFFF_FFFE, 32'h0,        1'b0, 0,  32'h2222_2222, 32'h0000_00F8};
        vecs[4] = '{1'b1, 2'b10, 32'h0,        32'h0000_2003, 1'b1, 2,  32'h3333_3333, 32'h0000_2000};
        vecs[5] = '{1'b1, 2'b11, 32'h0000_0040, 32'h0000_5000, 1'b0, 3,  32'h4444_4444, 32'h0000_2004};
        vecs[6] = '{1'b1, 2'b00, 32'h0000_0040, 32'h0000_5000, 1'b0, 0,  32'h5555_5555, 32'h0000_2008};
        vecs[7] = '{1'b1, 2'b01, 32'h0000_0004, 32'h0,        1'b0, 14, 32'h6666_6666, 32'h0000_2018};
        vecs[8] = '{1'b1, 2'b10, 32'h0,        32'hFFFF_FFFF, 1'b0, 0,  32'h6666_7777, 32'hFFFF_FFFC};

        tick();
        tick();
        reset = 1'b0;
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_pc", pc, 32'h0);
        check("rst_last_pc", last_pc, 32'h0);
        check("rst_IR", IR, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        for (int k = 0; k < 9; k++) begin
            if (vecs[k].pc_load) begin
                pc_load     = 1'b1;
                pc_src      = vecs[k].pc_src;
                branch_off  = vecs[k].branch_off;
                reg_target  = vecs[k].reg_target;
                fetch_start = vecs[k].with_start;
                tick();
                pc_load = 1'b0; fetch_start = 1'b0;
                check($sformatf("redir_mem_req_v%0d", k), mem_req, 0);
                check($sformatf("redir_busy_v%0d", k), busy, 0);
            end
            check($sformatf("pc_v%0d", k), pc, vecs[k].exp_pc);
            do_fetch(vecs[k].delay, vecs[k].rdata, vecs[k].exp_pc);
            tick();
        end
        check("wrap_pc", pc, 32'h0);

        // ack while IDLE must not load IR
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_IR", IR, 32'h6666_7777);
        check("idle_ack_ir_valid", ir_valid, 0);
        check("idle_ack_pc", pc, 32'h0);

        // timeout: still waiting after 14 silent cycles, ERR after the 15th
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("to_14_mem_req", mem_req, 1);
        check("to_14_err", fetch_err, 0);
        tick();
        check("to_15_err", fetch_err, 1);
        check("to_15_mem_req", mem_req, 0);
        check("to_15_busy", busy, 0);
        mem_ack = 1'b1; fetch_start = 1'b1; pc_load = 1'b1; pc_src = 2'b10; reg_target = 32'h400;
        for (int i = 0; i < 3; i++) tick();
        mem_ack = 1'b0; fetch_start = 1'b0; pc_load = 1'b0;
        check("err_sticky", fetch_err, 1);
        check("err_mem_req", mem_req, 0);
        check("err_pc", pc, 32'h0);
        check("err_IR", IR, 32'h6666_7777);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_rst_fetch_err", fetch_err, 0);
        check("err_rst_pc", pc, 32'h0);

        // reset mid-WAIT with a coincident ack abandons the fetch
        do_fetch(0, 32'h5A5A_A5A5, 32'h0);
        tick();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        reset = 1'b0; mem_ack = 1'b0;
        check("midwait_IR", IR, 32'h0);
        check("midwait_ir_valid", ir_valid, 0);
        check("midwait_mem_req", mem_req, 0);
        check("midwait_pc", pc, 32'h0);
        check("midwait_last_pc", last_pc, 32'h0);
        tick();
        tick();
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
